// File: rtl/cipher_entry_pkg.sv
// Shared definitions for the cipher front-panel controller: FSM states,
// mode switch encodings, button indices and the 7-segment hex font.
package cipher_entry_pkg;

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Mode switch encodings.
  localparam logic [1:0] MODE_DATA = 2'b00;
  localparam logic [1:0] MODE_KEY  = 2'b01;
  localparam logic [1:0] MODE_RES  = 2'b10;
  localparam logic [1:0] MODE_RUN  = 2'b11;

  // Button positions within btn_n.
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_SET   = 2;
  localparam int NUM_BTN   = 3;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex digit to active-low segments, bit order gfedcba.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/btn_cond.sv
// Button conditioner: two-flop synchroniser, debounce, and a one-cycle
// event on the press (falling) edge of an active-low button.
module btn_cond #(
  parameter int DEB_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [DEB_W-1:0] cnt;

  // Bring the raw pin into the clock domain; idle level is released (1).
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it differs from the stable level for
  // 2^DEB_W consecutive cycles; emit a pulse when the new level is pressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b1;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (&cnt) begin
        cnt    <= '0;
        stable <= sync2;
        press  <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cipher_entry_ctrl.sv
// Front-panel controller for the block-cipher demonstrator: nibble editing
// of plaintext and key, start/done handshake with the cipher core, result
// capture and a windowed multi-digit 7-segment display.
// Optional feature: define CIPHER_ENTRY_CHAIN_EN so that a right event in
// DONE copies the result into the plaintext register (cipher chaining).
module cipher_entry_ctrl
  import cipher_entry_pkg::*;
#(
  parameter int              DATA_W   = 128,
  parameter int              KEY_W    = 256,
  parameter int              DIGITS   = 8,
  parameter int              DEB_W    = 16,
  parameter int              BLINK_W  = 24,
  parameter logic [KEY_W-1:0] KEY_INIT = '0,
  localparam int             WIN_CNT  = KEY_W / (DIGITS * 4),
  localparam int             WS       = (WIN_CNT > 1) ? $clog2(WIN_CNT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            btn_n,
  input  logic [1:0]            mode,
  input  logic [WS-1:0]         win_sel,
  input  logic [3:0]            nib_in,
  input  logic                  rev_key,
  input  logic [DATA_W-1:0]     core_dout,
  input  logic                  core_done,
  output logic                  core_start,
  output logic [DATA_W-1:0]     core_data,
  output logic [KEY_W-1:0]      core_key,
  output logic [DIGITS*7-1:0]   seg_n,
  output logic [3:0]            mode_led,
  output logic                  busy,
  output logic                  done_led
);

  localparam int CW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DATA_NIBS = DATA_W / 4;
  localparam int KEY_NIBS  = KEY_W / 4;
  localparam int KEY_WORDS = KEY_W / 32;
  localparam int SRC_W     = (DATA_W > KEY_W) ? DATA_W : KEY_W;
  localparam logic [CW-1:0] CUR_MAX = CW'(DIGITS - 1);

  state_t              state_q;
  state_t              state_d;
  logic [DATA_W-1:0]   data_q;
  logic [KEY_W-1:0]    key_q;
  logic [DATA_W-1:0]   result_q;
  logic [CW-1:0]       cursor_q;
  logic [BLINK_W-1:0]  blink_q;

  logic [NUM_BTN-1:0]  btn_ev_raw;
  logic                single_ev;
  logic                ev_left;
  logic                ev_right;
  logic                ev_set;
  logic                in_edit;
  logic                edit_mode;
  int                  wr_idx;

  // ---------------------------------------------------------------------
  // Button conditioning and event qualification
  // ---------------------------------------------------------------------
  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    btn_cond #(.DEB_W(DEB_W)) u_btn_cond (
      .clk   (clk),
      .reset (reset),
      .btn_n (btn_n[b]),
      .press (btn_ev_raw[b])
    );
  end

  // Coincident events are ambiguous, so only a lone event is acted upon.
  assign single_ev = $onehot(btn_ev_raw);
  assign ev_left   = single_ev & btn_ev_raw[BTN_LEFT];
  assign ev_right  = single_ev & btn_ev_raw[BTN_RIGHT];
  assign ev_set    = single_ev & btn_ev_raw[BTN_SET];

  assign in_edit   = (state_q == EDIT);
  assign edit_mode = (mode == MODE_DATA) || (mode == MODE_KEY);
  assign wr_idx    = int'(win_sel) * DIGITS + int'(cursor_q);

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EDIT;
    else       state_q <= state_d;
  end

  // Next-state and handshake/status outputs.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    busy       = 1'b0;
    done_led   = 1'b0;
    case (state_q)
      EDIT: begin
        if (ev_set && (mode == MODE_RUN)) state_d = START;
      end
      START: begin
        core_start = 1'b1;
        busy       = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (core_done) state_d = DONE;
      end
      DONE: begin
        done_led = 1'b1;
        if (single_ev) state_d = EDIT;
      end
      default: state_d = EDIT;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  // Cursor moves with wrap-around, only while editing data or key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cursor_q <= '0;
    end else if (in_edit && edit_mode) begin
      if (ev_left)       cursor_q <= (cursor_q == CUR_MAX) ? '0 : cursor_q + 1'b1;
      else if (ev_right) cursor_q <= (cursor_q == '0) ? CUR_MAX : cursor_q - 1'b1;
    end
  end

  // Plaintext nibble writes; indices beyond the register match no slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (in_edit && ev_set && (mode == MODE_DATA)) begin
      for (int n = 0; n < DATA_NIBS; n++) begin
        if (n == wr_idx) data_q[4*n +: 4] <= nib_in;
      end
    end
`ifdef CIPHER_ENTRY_CHAIN_EN
    else if ((state_q == DONE) && ev_right) begin
      data_q <= result_q;
    end
`endif
  end

  // Key nibble writes; indices beyond the register match no slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q <= KEY_INIT;
    end else if (in_edit && ev_set && (mode == MODE_KEY)) begin
      for (int n = 0; n < KEY_NIBS; n++) begin
        if (n == wr_idx) key_q[4*n +: 4] <= nib_in;
      end
    end
  end

  // Capture the core result when completion is seen while waiting for it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             result_q <= '0;
    else if ((state_q == WAIT) && core_done) result_q <= core_dout;
  end

  // Free-running blink timer; its MSB is the cursor phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) blink_q <= '0;
    else       blink_q <= blink_q + 1'b1;
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign core_data = data_q;
  assign mode_led  = 4'b0001 << mode;

  // Optional reversal of the 32-bit word order of the key.
  always_comb begin
    core_key = key_q;
    if (rev_key) begin
      for (int i = 0; i < KEY_WORDS; i++) begin
        core_key[32*i +: 32] = key_q[32*(KEY_WORDS-1-i) +: 32];
      end
    end
  end

  // Select the display source and render the current window of digits.
  always_comb begin
    logic             show_res;
    logic             show_key;
    logic             cur_blank;
    logic [SRC_W-1:0] src_vec;
    int               src_nibs;
    int               n;
    logic [3:0]       nib;

    show_res  = (mode == MODE_RES) || (state_q == DONE);
    show_key  = !show_res && (mode == MODE_KEY);
    cur_blank = in_edit && edit_mode && !blink_q[BLINK_W-1];

    if (show_key) begin
      src_vec  = SRC_W'(core_key);
      src_nibs = KEY_NIBS;
    end else if (show_res) begin
      src_vec  = SRC_W'(result_q);
      src_nibs = DATA_NIBS;
    end else begin
      src_vec  = SRC_W'(data_q);
      src_nibs = DATA_NIBS;
    end

    seg_n = '0;
    for (int d = 0; d < DIGITS; d++) begin
      n   = int'(win_sel) * DIGITS + d;
      nib = 4'(src_vec >> (4 * n));
      if ((n >= src_nibs) || (cur_blank && (d == int'(cursor_q))))
        seg_n[7*d +: 7] = SEG_BLANK;
      else
        seg_n[7*d +: 7] = hex_to_seg(nib);
    end
  end

endmodule
